// File: rtl/mem_word_bridge.sv
// mem_word_bridge: splits 32-bit CPU loads/stores into two 16-bit beats on a synchronous memory port.
// Little-endian: low half at addr, high half at addr+1 (wrapping).
module mem_word_bridge #(
  parameter int ADDR_W = 8,
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*HALF_W-1:0] req_wdata,
  output logic                resp_valid,
  output logic [2*HALF_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [HALF_W-1:0]   mem_data_in,
  output logic                mem_write_enable,
  output logic                mem_read_enable,
  input  logic [HALF_W-1:0]   mem_data_out
);
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_address_q, mem_address_d;
  logic [2*HALF_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [HALF_W-1:0] lo_q, lo_d, mem_data_in_q, mem_data_in_d;
  logic write_q, write_d, ready_q, ready_d, resp_q, resp_d, we_q, we_d, re_q, re_d;
  logic lo_beat, hi_beat;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    lo_d = lo_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_valid && ready_q) begin
        addr_d = req_addr;
        wdata_d = req_wdata;
        write_d = req_write;
        state_d = req_write ? WR_LO : RD_LO;
      end
      WR_LO: state_d = WR_HI;
      WR_HI: state_d = RESP;
      RD_LO: state_d = RD_HI;
      RD_HI: begin
        lo_d = mem_data_out;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = {mem_data_out, lo_q};
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered: decode them from the state being entered.
    lo_beat = state_d == WR_LO || state_d == RD_LO;
    hi_beat = state_d == WR_HI || state_d == RD_HI;
    ready_d = state_d == IDLE;
    resp_d = state_d == RESP;
    we_d = state_d == WR_LO || state_d == WR_HI;
    re_d = state_d == RD_LO || state_d == RD_HI;
    mem_address_d = hi_beat ? addr_d + 1'b1 : lo_beat ? addr_d : '0;
    mem_data_in_d = state_d == WR_LO ? wdata_d[HALF_W-1:0] :
                    state_d == WR_HI ? wdata_d[2*HALF_W-1:HALF_W] : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      lo_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      resp_q <= 1'b0;
      we_q <= 1'b0;
      re_q <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      lo_q <= lo_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      resp_q <= resp_d;
      we_q <= we_d;
      re_q <= re_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end
  assign req_ready = ready_q;
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_write_enable = we_q;
  assign mem_read_enable = re_q;
endmodule

// File: tb/tb_mem_word_bridge.sv
// tb_mem_word_bridge: directed checks of mem_word_bridge against a 256x16 registered memory model.
module tb_mem_word_bridge;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_write, resp_valid;
  logic [7:0] req_addr, mem_address;
  logic [31:0] req_wdata, resp_rdata;
  logic [15:0] mem_data_in, mem_data_out;
  logic mem_write_enable, mem_read_enable;
  logic [15:0] mem [0:255];
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  mem_word_bridge dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_data_out(mem_data_out)
  );
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem_data_out = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_data_in;
    if (mem_read_enable) mem_data_out <= mem[mem_address];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
    int i;
    @(posedge clk);
    #1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
    i = 0;
    @(negedge clk);
    while (!req_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask
  task automatic wait_resp(input string tag, input int lat, input logic [31:0] exp);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 12);
    check({tag, "_latency"}, k, lat);
    check({tag, "_rdata"}, resp_rdata, exp);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
  endtask
  initial begin
    logic [7:0] addrs [0:2];
    logic [31:0] exps [0:2];
    int acc_t [0:2];
    int nacc, nresp, npulse;
    logic acc;
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 8'h55;
    req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_enables", {30'b0, mem_write_enable, mem_read_enable}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    // Store then load at 0x10.
    issue(1'b1, 8'h10, 32'hDEAD_BEEF);
    check("wr_lo_beat", {mem_write_enable, mem_read_enable, 6'b0, mem_address, mem_data_in}, {2'b10, 6'b0, 8'h10, 16'hBEEF});
    wait_resp("store10", 3, 32'd0);
    check("mem10", {16'b0, mem[8'h10]}, 32'h0000_BEEF);
    check("mem11", {16'b0, mem[8'h11]}, 32'h0000_DEAD);
    issue(1'b0, 8'h10, 32'h0);
    wait_resp("load10", 4, 32'hDEAD_BEEF);
    // Address wrap at 0xFF.
    issue(1'b1, 8'hFF, 32'h1234_5678);
    wait_resp("storeFF", 3, 32'hDEAD_BEEF);
    check("memFF", {16'b0, mem[8'hFF]}, 32'h0000_5678);
    check("mem00", {16'b0, mem[8'h00]}, 32'h0000_1234);
    issue(1'b0, 8'hFF, 32'h0);
    wait_resp("loadFF", 4, 32'h1234_5678);
    // Three loads with req_valid held high.
    addrs[0] = 8'h10; addrs[1] = 8'hFF; addrs[2] = 8'h11;
    exps[0] = 32'hDEAD_BEEF; exps[1] = 32'h1234_5678; exps[2] = 32'h0000_DEAD;
    nacc = 0;
    nresp = 0;
    @(posedge clk);
    #1;
    req_write = 1'b0;
    req_addr = addrs[0];
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = 1'b0;
      @(negedge clk);
      if (resp_valid) begin
        check("b2b_rdata", resp_rdata, exps[nresp > 2 ? 2 : nresp]);
        nresp++;
      end
      if (req_ready && nacc < 3) begin
        acc_t[nacc] = c;
        nacc++;
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (nacc < 3) req_addr = addrs[nacc];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", nacc, 3);
    check("b2b_responses", nresp, 3);
    check("b2b_gap1", acc_t[1] - acc_t[0], 5);
    check("b2b_gap2", acc_t[2] - acc_t[1], 5);
    // Reset lands on the WR_LO->WR_HI edge: only the low half is written.
    issue(1'b1, 8'h20, 32'hAAAA_5555);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_mem20", {16'b0, mem[8'h20]}, 32'h0000_5555);
    check("abort_mem21", {16'b0, mem[8'h21]}, 32'h0000_0000);
    check("abort_we", {31'b0, mem_write_enable}, 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    npulse = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) npulse++;
    end
    check("abort_no_resp", npulse, 0);
    // A store between two loads leaves resp_rdata alone.
    issue(1'b0, 8'h10, 32'h0);
    wait_resp("load_a", 4, 32'hDEAD_BEEF);
    issue(1'b1, 8'h30, 32'h1111_2222);
    wait_resp("store_mid", 3, 32'hDEAD_BEEF);
    check("mem30", {16'b0, mem[8'h30]}, 32'h0000_2222);
    check("mem31", {16'b0, mem[8'h31]}, 32'h0000_1111);
    issue(1'b0, 8'hFF, 32'h0);
    wait_resp("load_b", 4, 32'h1234_5678);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
